// File: rtl/subblock_deinterleaver_ctrl.sv
// subblock_deinterleaver_ctrl: writes column-permuted symbols to RAM at row-major positions, then reads them back skipping dummies
module subblock_deinterleaver_ctrl #(
  parameter int C = 32,
  parameter int OP_MODE = 0,
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [6:0]    R,
  input  logic [11:0]   D,
  input  logic [4:0]    n_dummy,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state;
  logic [6:0] r_q, row;
  logic [11:0] d_q, cnt;
  logic [4:0] nd_q, col, p;
  logic [AW-1:0] rd;
  logic [12:0] base, base1, kpi, need;
  logic acc, cfg_bad, row_end;
  assign in_ready = state == WRITE;
  assign busy = state != IDLE;
  assign acc = in_valid && in_ready;
  assign need = 13'(D) + 13'(n_dummy);
  assign cfg_bad = R == 7'd0 || need != {1'b0, R, 5'b0};
  // the column permutation is the 5-bit bit reversal of the column index
  assign p = {col[0], col[1], col[2], col[3], col[4]};
  assign kpi = {1'b0, r_q, 5'b0};
  assign base = {1'b0, row, 5'b0} + 13'(p);
  assign base1 = (base + 13'd1 == kpi) ? '0 : base + 13'd1;
  assign row_end = row == r_q - 7'd1;
  assign ram_we = acc;
  assign ram_waddr = acc ? AW'(OP_MODE == 1 ? base1 : base) : '0;
  assign ram_wdata = acc ? in_data : '0;
  assign ram_raddr = rd;
  assign out_data = out_valid ? ram_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r_q <= '0;
      d_q <= '0;
      nd_q <= '0;
      col <= '0;
      row <= '0;
      rd <= '0;
      cnt <= '0;
      ram_re <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done <= 1'b0;
      out_valid <= ram_re;
      out_last <= ram_re && cnt == d_q - 12'd1;
      case (state)
        IDLE: if (start) begin
          r_q <= R;
          d_q <= D;
          nd_q <= n_dummy;
          cfg_err <= cfg_bad;
          if (!cfg_bad) begin
            col <= '0;
            row <= '0;
            state <= WRITE;
          end
        end
        WRITE: if (acc) begin
          row <= row_end ? '0 : row + 7'd1;
          if (row_end) begin
            col <= col + 5'd1;
            if (col == 5'(C - 1)) begin
              state <= READ;
              ram_re <= 1'b1;
              rd <= AW'(nd_q);
              cnt <= '0;
            end
          end
        end
        READ: begin
          if (ram_re) begin
            if (cnt == d_q - 12'd1) ram_re <= 1'b0;
            else begin
              rd <= rd + 1'b1;
              cnt <= cnt + 12'd1;
            end
          end
          if (out_last) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/subblock_deinterleaver_ctrl.md
Name: subblock_deinterleaver_ctrl

Overview:
- Receive-side counterpart of the 32-column sub-block interleaver RAM controller.
- Accepts a stream of interleaved symbols in column-permuted order and writes each symbol to the deinterleaver RAM at its original row-major position.
- Reads the RAM back row-wise, skipping the leading dummy positions, and emits D deinterleaved symbols in original order.
- Sits between the rate-dematching/symbol input stage and the decoder input buffer; owns the RAM write and read ports.

Parameters:
- C, 32: column count. Fixed; the bit-reversal permutation table is 32 entries.
- OP_MODE, 0: 0 selects the systematic/parity-1 mapping; 1 selects the parity-2 mapping (+1 offset, modulo K_pi).
- DW, 8: symbol width in bits.
- AW, 12: RAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a block. Ignored unless the block is idle.
- R  in  7  row count; K_pi = 32*R.
- D  in  12  payload length.
- n_dummy  in  5  number of dummy positions.
- in_valid  in  1  input symbol valid.
- in_data  in  DW  input symbol.
- in_ready  out  1  high while the block accepts symbols.
- ram_we  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  DW  RAM write data.
- ram_raddr  out  AW  RAM read address.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DW  RAM read data, valid exactly one cycle after ram_re.
- out_valid  out  1  output symbol valid.
- out_data  out  DW  output symbol.
- out_last  out  1  marks the final (D-th) output symbol.
- busy  out  1  block is in WRITE or READ.
- done  out  1  single-cycle pulse at block completion.
- cfg_err  out  1  sticky flag, set on an invalid configuration; cleared by the next valid start or by reset.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE.
  - All outputs 0 (in_ready, ram_we, ram_re, out_valid, out_last, busy, done, cfg_err, and all address/data buses).
  - All counters 0.
  - Reset mid-block aborts immediately; no further RAM or output activity occurs.
- Permutation: P = {0,16,8,24,4,20,12,28,2,18,10,26,6,22,14,30,1,17,9,25,5,21,13,29,3,19,11,27,7,23,15,31}.
- IDLE:
  - On start, latch R, D and n_dummy.
  - If R==0, or D+n_dummy != 32*R (computed in 13 bits), set cfg_err and stay in IDLE.
  - Otherwise clear cfg_err, set col=0, row=0, and go to WRITE.
- WRITE:
  - in_ready=1 and busy=1.
  - On each accepted symbol (in_valid & in_ready), in the same cycle: ram_we=1, ram_wdata=in_data.
  - ram_waddr = P[col] + 32*row when OP_MODE=0.
  - ram_waddr = (P[col] + 32*row + 1) mod K_pi when OP_MODE=1; a result equal to K_pi becomes 0.
  - ram_we/ram_waddr/ram_wdata are combinational from the handshake; the counters update registered.
  - Counter order: row increments 0..R-1; on wrap, row returns to 0 and col increments.
  - No handshake means ram_we=0 and the counters hold. Gaps of any length are legal.
  - Dummy positions are written with whatever symbol arrives; the upstream stage supplies fillers.
  - After the accept at col=31, row=R-1: in_ready drops the next cycle, rd=n_dummy, go to READ.
- READ:
  - busy=1. Each cycle, ram_re=1 and ram_raddr=rd, rd increments; this repeats for D cycles (rd = n_dummy .. n_dummy+D-1).
  - A registered one-cycle-delayed copy of ram_re drives out_valid; out_data=ram_rdata on that cycle.
  - out_last accompanies the D-th out_valid.
  - There is no output backpressure; downstream must accept one symbol per cycle.
- Completion:
  - The cycle after out_last: done=1 for one cycle, busy=0, state=IDLE.
  - Latency from the last input accept to the first out_valid is 2 cycles.
  - Total READ-phase cycles = D+1.
- start while busy: ignored; no state or cfg_err change.
- Read/write hazard: none. Reads begin only after all 32*R writes are issued; the RAM is write-first or registered.

Test Plan:
- R=1, D=32, n_dummy=0, OP_MODE=0, inputs 0..31:
  - Write addresses are 0,16,8,24,4,...,31.
  - Outputs are 0,16,8,24,... (out[j]=bitrev5(j)); out_last on the 32nd output; done one cycle later.
- R=2, D=60, n_dummy=4, OP_MODE=0, inputs 0..63:
  - Write addresses are 0,32,16,48,8,40,...
  - Exactly 60 outputs, reading RAM addresses 4..63; out_valid first appears 2 cycles after the last accept.
- OP_MODE=1, R=2, n_dummy=0:
  - Input index 62 (col31,row0) writes address 32.
  - Input index 63 (col31,row1) writes address 0 (wrap).
  - Input index 0 writes address 1.
- Random in_valid gaps (~40% idle):
  - Write-address sequence identical to the gap-free case.
  - ram_we never asserts without in_valid.
- Reset asserted after 20 accepts in WRITE:
  - Next cycle, all outputs are 0 and state is IDLE.
  - A fresh start then completes normally.
- start with R=2, D=60, n_dummy=5 -> cfg_err=1, in_ready stays 0. A second start pulse during a valid READ is ignored and the block completes unchanged.
